// File: rtl/usb_tx_sequencer.sv
// USB bulk-endpoint transmit sequencer: paces bit slots for the NRZI encoder
// and drives SYNC, LSB-first payload, stuff bits and the SE0/SE0/J end-of-packet.
module usb_tx_sequencer #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tx_start,
   input  logic [6:0] tx_size,
   input  logic [7:0] tx_data,
   output logic       get_byte,
   output logic       clk12,
   output logic       serial_out,
   output logic       enc_en,
   output logic       bit_stuff_en,
   output logic       eop_en,
   output logic       eop_reset,
   output logic       bytecomplete,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int TW = $clog2(CLK_DIV);
   localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_DATA,
      S_STUFF,
      S_EOP1,
      S_EOP2,
      S_EOPJ
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    ones_q, ones_d;
   logic [2:0]    bitidx_q, bitidx_d;
   logic [7:0]    shift_q, shift_d;
   logic [6:0]    left_q, left_d;
   logic          last_q, last_d;
   logic          done_q, done_d;

   logic          strobe;
   logic [2:0]    ones_nx;
   logic          stuff_nx;

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      ones_d       = ones_q;
      bitidx_d     = bitidx_q;
      shift_d      = shift_q;
      left_d       = left_q;
      last_d       = last_q;
      done_d       = 1'b0;
      get_byte     = 1'b0;
      serial_out   = 1'b0;
      enc_en       = 1'b0;
      bit_stuff_en = 1'b0;
      eop_en       = 1'b0;
      eop_reset    = 1'b0;
      bytecomplete = 1'b0;
      ones_nx      = 3'd0;
      stuff_nx     = 1'b0;

      strobe = (state_q != S_IDLE) && (timer_q == TMAX);

      if (state_q != S_IDLE) begin
         timer_d = strobe ? '0 : timer_q + TW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (tx_start) begin
               state_d  = S_SYNC;
               left_d   = tx_size;
               timer_d  = '0;
               ones_d   = 3'd0;
               bitidx_d = 3'd0;
               shift_d  = 8'h80;
               last_d   = 1'b0;
            end
         end

         S_SYNC, S_DATA: begin
            if (strobe) begin
               enc_en     = 1'b1;
               serial_out = shift_q[0];
               ones_nx    = shift_q[0] ? ones_q + 3'd1 : 3'd0;
               stuff_nx   = (ones_nx == 3'd6);
               ones_d     = ones_nx;
               if (bitidx_q != 3'd7) begin
                  bitidx_d = bitidx_q + 3'd1;
                  shift_d  = {1'b0, shift_q[7:1]};
                  state_d  = stuff_nx ? S_STUFF : state_q;
               end else begin
                  bytecomplete = 1'b1;
                  bitidx_d     = 3'd0;
                  if (left_q != 7'd0) begin
                     // FIFO head is consumed in this same cycle
                     get_byte = 1'b1;
                     shift_d  = tx_data;
                     left_d   = left_q - 7'd1;
                     state_d  = stuff_nx ? S_STUFF : S_DATA;
                  end else begin
                     last_d  = 1'b1;
                     state_d = stuff_nx ? S_STUFF : S_EOP1;
                  end
               end
            end
         end

         S_STUFF: begin
            if (strobe) begin
               bit_stuff_en = 1'b1;
               ones_d       = 3'd0;
               state_d      = last_q ? S_EOP1 : S_DATA;
            end
         end

         S_EOP1: begin
            if (strobe) begin
               eop_en  = 1'b1;
               state_d = S_EOP2;
            end
         end

         S_EOP2: begin
            if (strobe) begin
               eop_en  = 1'b1;
               state_d = S_EOPJ;
            end
         end

         S_EOPJ: begin
            if (strobe) begin
               eop_reset = 1'b1;
               state_d   = S_IDLE;
               done_d    = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign clk12   = strobe;
   assign tx_busy = (state_q != S_IDLE);
   assign tx_done = done_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         ones_q   <= 3'd0;
         bitidx_q <= 3'd0;
         left_q   <= 7'd0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         ones_q   <= ones_d;
         bitidx_q <= bitidx_d;
         left_q   <= left_d;
         last_q   <= last_d;
         done_q   <= done_d;
      end
   end

   // Shift register is pure data: always loaded on accept before use
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer: per-strobe slot capture compared
// against hand-derived packet lengths/positions and a bit-level stuffing model.
module tb_usb_tx_sequencer;

   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       tx_start = 1'b0;
   logic [6:0] tx_size = 7'd0;
   logic [7:0] tx_data = 8'd0;
   logic       get_byte, clk12, serial_out, enc_en, bit_stuff_en;
   logic       eop_en, eop_reset, bytecomplete, tx_busy, tx_done;

   always #5 clk = ~clk;

   usb_tx_sequencer #(.CLK_DIV(CLK_DIV)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .tx_start     (tx_start),
      .tx_size      (tx_size),
      .tx_data      (tx_data),
      .get_byte     (get_byte),
      .clk12        (clk12),
      .serial_out   (serial_out),
      .enc_en       (enc_en),
      .bit_stuff_en (bit_stuff_en),
      .eop_en       (eop_en),
      .eop_reset    (eop_reset),
      .bytecomplete (bytecomplete),
      .tx_busy      (tx_busy),
      .tx_done      (tx_done)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] fifo [0:7];
   int fifo_idx;
   int got_code[$], got_k[$], got_bc[$], got_gb[$];
   int exp_code[$], exp_bc[$];
   int done_k;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] outvec();
      return {get_byte, clk12, serial_out, enc_en, bit_stuff_en,
              eop_en, eop_reset, bytecomplete, tx_busy, tx_done};
   endfunction

   // Codes: 0/1 data bit, 2 stuff, 3 SE0, 4 J, 9 not exactly one slot control
   function automatic int slot_code();
      int nh;
      nh = int'(enc_en) + int'(bit_stuff_en) + int'(eop_en) + int'(eop_reset);
      if (nh != 1)      return 9;
      if (enc_en)       return int'(serial_out);
      if (bit_stuff_en) return 2;
      if (eop_en)       return 3;
      return 4;
   endfunction

   function automatic void build_model(input int n);
      int ones;
      logic [7:0] by;
      exp_code.delete();
      exp_bc.delete();
      ones = 0;
      for (int b = 0; b <= n; b++) begin
         by = (b == 0) ? 8'h80 : fifo[b-1];
         for (int i = 0; i < 8; i++) begin
            exp_code.push_back(int'(by[i]));
            if (i == 7) exp_bc.push_back(exp_code.size());
            ones = by[i] ? ones + 1 : 0;
            if (ones == 6) begin
               exp_code.push_back(2);
               ones = 0;
            end
         end
      end
      exp_code.push_back(3);
      exp_code.push_back(3);
      exp_code.push_back(4);
   endfunction

   function automatic int stuff_pos(input int nth);
      int seen;
      seen = 0;
      foreach (got_code[i]) begin
         if (got_code[i] == 2) begin
            seen++;
            if (seen == nth) return i + 1;
         end
      end
      return -1;
   endfunction

   function automatic int stuff_count();
      int c;
      c = 0;
      foreach (got_code[i]) if (got_code[i] == 2) c++;
      return c;
   endfunction

   task automatic send(input int n, input int retrig_k, input bit hold, input int exp_len);
      int k, quiet, spacing, gb_bad, busy_bad, prev_k, nx, extra_done, extra_busy;
      bit done_seen, pop_pend;
      got_code.delete(); got_k.delete(); got_bc.delete(); got_gb.delete();
      build_model(n);
      k = 0; quiet = 0; spacing = 0; gb_bad = 0; busy_bad = 0; prev_k = -1;
      done_seen = 1'b0; pop_pend = 1'b0; done_k = -1;
      @(negedge clk);
      tx_size  = 7'(n);
      tx_start = 1'b1;
      fifo_idx = 0;
      tx_data  = fifo[0];
      while (!done_seen && k < 600) begin
         @(negedge clk);
         k++;
         if (k == 1 || k == retrig_k + 1) tx_start = 1'b0;
         if (k == retrig_k) tx_start = 1'b1;
         if (pop_pend && fifo_idx < 7) begin
            fifo_idx++;
            tx_data = fifo[fifo_idx];
         end
         pop_pend = get_byte;
         if (k == 1) chk("busy_rise", int'(tx_busy), 1);
         if (tx_done) begin
            done_seen = 1'b1;
            done_k = k;
            chk("busy_at_done", int'(tx_busy), 0);
            if (hold) tx_start = 1'b1;
         end else if (!tx_busy) begin
            busy_bad++;
         end
         if (clk12) begin
            got_code.push_back(slot_code());
            got_k.push_back(k);
            if (prev_k >= 0 && k - prev_k != CLK_DIV) spacing++;
            prev_k = k;
            if (bytecomplete) got_bc.push_back(got_code.size());
            if (get_byte) begin
               got_gb.push_back(got_code.size());
               if (!bytecomplete) gb_bad++;
            end
         end else if (get_byte | serial_out | enc_en | bit_stuff_en |
                      eop_en | eop_reset | bytecomplete) begin
            quiet++;
         end
      end
      chk("done_seen", int'(done_seen), 1);
      chk("first_strobe", (got_k.size() > 0) ? got_k[0] : -1, CLK_DIV);
      chk("strobe_count", got_code.size(), exp_len);
      nx = (got_code.size() < exp_code.size()) ? got_code.size() : exp_code.size();
      for (int i = 0; i < nx; i++) chk($sformatf("slot%0d", i + 1), got_code[i], exp_code[i]);
      chk("spacing_errs", spacing, 0);
      chk("quiet_errs", quiet, 0);
      chk("busy_drop", busy_bad, 0);
      chk("get_byte_count", got_gb.size(), n);
      chk("get_byte_off_bc", gb_bad, 0);
      chk("bc_count", got_bc.size(), exp_bc.size());
      nx = (got_bc.size() < exp_bc.size()) ? got_bc.size() : exp_bc.size();
      for (int i = 0; i < nx; i++) chk($sformatf("bc%0d", i), got_bc[i], exp_bc[i]);
      chk("done_latency", done_k, (got_k.size() > 0) ? got_k[got_k.size()-1] + 1 : -99);
      if (!hold) begin
         extra_done = 0; extra_busy = 0;
         repeat (2 * CLK_DIV) begin
            @(negedge clk);
            if (tx_done) extra_done++;
            if (tx_busy) extra_busy++;
         end
         chk("extra_done", extra_done, 0);
         chk("idle_busy", extra_busy, 0);
      end
   endtask

   initial begin
      int j, sc;
      bit seen;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_outputs", int'(outvec()), 0);
      n_rst = 1'b1;
      @(negedge clk);
      chk("idle_outputs", int'(outvec()), 0);

      // N=0: SYNC + EOP only
      send(0, 0, 1'b0, 11);

      // N=1 A5 with tx_start pulsed mid-DATA (cycle 40 ~ strobe 10)
      fifo[0] = 8'hA5;
      send(1, 40, 1'b0, 19);
      chk("a5_bc0", (got_bc.size() > 0) ? got_bc[0] : -1, 8);
      chk("a5_bc1", (got_bc.size() > 1) ? got_bc[1] : -1, 16);
      chk("a5_gb_pos", (got_gb.size() > 0) ? got_gb[0] : -1, 8);
      chk("a5_stuffs", stuff_count(), 0);

      // N=1 FF: stuff on strobe 14
      fifo[0] = 8'hFF;
      send(1, 0, 1'b0, 20);
      chk("ff_stuff_pos", stuff_pos(1), 14);
      chk("ff_stuffs", stuff_count(), 1);

      // N=1 FC: stuff after final bit, then EOP; tx_start held in done cycle
      fifo[0] = 8'hFC;
      fifo[1] = 8'h00;
      send(1, 0, 1'b1, 20);
      chk("fc_stuff_pos", stuff_pos(1), 17);
      chk("fc_s18", (got_code.size() > 17) ? got_code[17] : -1, 3);
      chk("fc_s19", (got_code.size() > 18) ? got_code[18] : -1, 3);
      chk("fc_s20", (got_code.size() > 19) ? got_code[19] : -1, 4);

      // Restarted packet accepted in the tx_done cycle
      j = 0; seen = 1'b0;
      while (!seen && j < 20) begin
         @(negedge clk);
         j++;
         if (j == 1) begin
            tx_start = 1'b0;
            chk("restart_busy", int'(tx_busy), 1);
         end
         if (clk12) seen = 1'b1;
      end
      chk("restart_first_strobe", j, CLK_DIV);
      j = 0; seen = 1'b0;
      while (!seen && j < 300) begin
         @(negedge clk);
         j++;
         if (tx_done) seen = 1'b1;
      end
      chk("restart_done", int'(seen), 1);

      // N=2 FC,FE: stuff at a byte boundary with a byte still to pop, and mid-byte
      fifo[0] = 8'hFC;
      fifo[1] = 8'hFE;
      send(2, 0, 1'b0, 29);
      chk("n2_gb0", (got_gb.size() > 0) ? got_gb[0] : -1, 8);
      chk("n2_gb1", (got_gb.size() > 1) ? got_gb[1] : -1, 16);
      chk("n2_stuff1", stuff_pos(1), 17);
      chk("n2_stuff2", stuff_pos(2), 25);
      chk("n2_bc2", (got_bc.size() > 2) ? got_bc[2] : -1, 26);

      // Reset mid-DATA after four consecutive ones (SYNC 1 + three payload 1s)
      @(negedge clk);
      tx_size  = 7'd3;
      tx_data  = 8'hFF;
      tx_start = 1'b1;
      j = 0; sc = 0;
      while (sc < 11 && j < 200) begin
         @(negedge clk);
         j++;
         if (j == 1) tx_start = 1'b0;
         if (clk12) sc++;
      end
      chk("abort_reached", sc, 11);
      n_rst = 1'b0;
      @(negedge clk);
      chk("abort_outputs", int'(outvec()), 0);
      n_rst = 1'b1;

      fifo[0] = 8'hFF;
      send(1, 0, 1'b0, 20);
      chk("post_rst_stuff_pos", stuff_pos(1), 14);
      chk("post_rst_stuffs", stuff_count(), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/usb_tx_sequencer.md
# usb_tx_sequencer

Transmit-side controller for the USB bulk endpoint. It sequences the NRZI line encoder through one packet. For each packet it generates the bit-rate strobe (`clk12`), serializes SYNC and N payload bytes LSB-first, inserts stuff bits after six consecutive ones, and drives the EOP sequence (SE0, SE0, J). It sits between the TX FIFO/packet controller and the encoder, and it owns every encoder control input.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per USB bit slot, ≥2.
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `tx_start`  in  1  request to send one packet; sampled only in IDLE.
- `tx_size`  in  7  payload byte count N, 0..64; latched when `tx_start` is accepted.
- `tx_data`  in  8  head byte of first-word-fall-through TX FIFO.
- `get_byte`  out  1  one-cycle FIFO pop; `tx_data` is consumed in the same cycle.
- `clk12`  out  1  one-cycle bit strobe to encoder.
- `serial_out`  out  1  current data bit.
- `enc_en`  out  1  data/SYNC bit slot; encoder holds the line on 1, toggles on 0.
- `bit_stuff_en`  out  1  stuff-bit slot; encoder toggles.
- `eop_en`  out  1  SE0 slot.
- `eop_reset`  out  1  J slot ending EOP.
- `bytecomplete`  out  1  high on the strobe of bit 7 of SYNC and each payload byte.
- `tx_busy`  out  1  packet in progress.
- `tx_done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SYNC, DATA, STUFF, EOP1, EOP2, EOPJ.
- **IDLE**
  - `clk12` is held 0, so the encoder holds J.
  - On `tx_start`: latch `tx_size`, clear the bit timer, ones counter and bit index, load the shift register with 8'h80, then enter SYNC.
- **Bit timer**
  - Counts 0..CLK_DIV-1 and wraps.
  - `clk12`=1 when the count equals CLK_DIV-1.
  - Each strobe consumes exactly one bit slot.
- **Slot controls**
  - `serial_out`, `enc_en`, `bit_stuff_en`, `eop_en`, `eop_reset` and `bytecomplete` are only meaningful in strobe cycles.
  - Outside strobe cycles they are 0.
  - In each strobe cycle exactly one of `enc_en`, `bit_stuff_en`, `eop_en`, `eop_reset` is 1.
- **SYNC/DATA slot**
  - `enc_en`=1 and `serial_out`=shift[0].
  - A 1 increments the ones counter; a 0 clears it.
  - Bit index 7 asserts `bytecomplete`.
- **Stuff rule**
  - When the ones counter reaches 6, the next slot is STUFF: `bit_stuff_en`=1, the counter clears, and the bit index and shift register do not advance.
  - Stuffing applies after the final payload bit too, before EOP.
- **Byte boundary** (strobe of bit 7, after any pending stuff decision is recorded)
  - If payload bytes remain: pulse `get_byte` and load the shift register from `tx_data`.
  - Otherwise: proceed to EOP1, via STUFF if the ones counter = 6.
- **EOP**
  - EOP1 and EOP2 each take one strobe with `eop_en`=1.
  - EOPJ takes one strobe with `eop_reset`=1.
  - Then return to IDLE and pulse `tx_done`.
- **Busy/ignore**
  - `tx_start` is ignored while not in IDLE.
  - `tx_size`/`tx_data` changes outside accept/pop cycles are ignored.
  - N=0 sends SYNC+EOP only, with no `get_byte`.

## Timing
- Reset value of all outputs: 0. The state returns to IDLE and all counters clear; the encoder's own reset restores J.
- `n_rst` asserted mid-packet aborts immediately. The next `tx_start` starts a clean packet with the ones counter at 0.
- After the `tx_start` cycle, the first strobe occurs exactly CLK_DIV cycles later. Strobes are spaced exactly CLK_DIV cycles apart.
- `tx_busy` rises the cycle after accept and stays high through the EOPJ strobe cycle.
- `tx_done`=1 the cycle after the EOPJ strobe, and `tx_busy`=0 in that cycle. A `tx_start` in the `tx_done` cycle is accepted.
- Packet length = 8 + 8N + S + 3 strobes, where S = stuff count.
- `get_byte` coincides with the `bytecomplete` strobe of the preceding byte. It occurs N times per packet.

## Test plan
- **N=0, CLK_DIV=4:** `tx_start` → 11 strobes, 4 clk apart.
  - `serial_out` 0,0,0,0,0,0,0,1 with `enc_en`=1.
  - Then `eop_en`×2, `eop_reset`×1.
  - `tx_done` 1 cycle after the last strobe, no `get_byte`.
- **N=1, tx_data=8'hA5:** 19 strobes; payload bits 1,0,1,0,0,1,0,1.
  - One `get_byte`, coincident with the SYNC bit-7 strobe.
  - `bytecomplete` on strobes 8 and 16.
- **N=1, 8'hFF:** SYNC's final 1 plus five payload 1s triggers STUFF on strobe 14.
  - The remaining three 1s follow, then EOP.
  - 20 strobes total, exactly one `bit_stuff_en`.
- **N=1, 8'hFC** (bits 0,0,1,1,1,1,1,1): stuff bit on strobe 17, `eop_en` on strobes 18–19, `eop_reset` on 20.
- **Re-trigger:** `tx_start` pulsed mid-DATA → ignored, exactly one `tx_done`.
  - `tx_start` held high in the `tx_done` cycle → a second packet starts and its first strobe follows CLK_DIV cycles later.
- **Reset mid-DATA** (N=3, after 4 consecutive ones): all outputs 0 next cycle.
  - A new N=1 8'hFF packet stuffs exactly at strobe 14, with no carried-over ones count.
